// File: rtl/arm_cond_pkg.sv
// ============================================================================
// Module : arm_cond_pkg
// Brief  : Condition-code enumeration and NZCV flag bit positions shared by
//          the conditional-execution stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arm_cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// ============================================================================
// Module : cond_check
// Brief  : Purely combinational evaluation of a 4-bit condition field against
//          the registered {N,Z,C,V} flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       cond_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = Flags[FLG_N];
    assign w_z = Flags[FLG_Z];
    assign w_c = Flags[FLG_C];
    assign w_v = Flags[FLG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond_e'(Cond))
            EQ: cond_pass = w_z;
            NE: cond_pass = ~w_z;
            CS: cond_pass = w_c;
            CC: cond_pass = ~w_c;
            MI: cond_pass = w_n;
            PL: cond_pass = ~w_n;
            VS: cond_pass = w_v;
            VC: cond_pass = ~w_v;
            HI: cond_pass = w_c & ~w_z;
            LS: cond_pass = ~w_c | w_z;
            GE: cond_pass = (w_n == w_v);
            LT: cond_pass = (w_n != w_v);
            GT: cond_pass = ~w_z & (w_n == w_v);
            LE: cond_pass = w_z | (w_n != w_v);
            AL: cond_pass = 1'b1;
            NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cond_logic.sv
// ============================================================================
// Module : cond_logic
// Brief  : Conditional-execution stage: NZCV register, strobe gating and
//          optional exec/annul counters (enabled by macro COND_PERF_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_logic
    import arm_cond_pkg::*;
#(
    parameter int         CNT_W     = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] annul_cnt
);

    logic [3:0] flags_q, flags_d;
    logic       w_cond_pass;

    // Evaluated against registered flags so a same-cycle flag write only
    // affects the following instruction.
    cond_check u_cond_check (
        .Cond      (Cond),
        .Flags     (flags_q),
        .cond_pass (w_cond_pass)
    );

    assign CondEx   = en & w_cond_pass;
    assign PCSrc    = PCS  & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (CondEx) begin
            if (FlagW[1]) begin
                flags_d[FLG_N] = ALUFlags[FLG_N];
                flags_d[FLG_Z] = ALUFlags[FLG_Z];
            end
            if (FlagW[0]) begin
                flags_d[FLG_C] = ALUFlags[FLG_C];
                flags_d[FLG_V] = ALUFlags[FLG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_PERF_EN
    logic [CNT_W-1:0] exec_cnt_q,  exec_cnt_d;
    logic [CNT_W-1:0] annul_cnt_q, annul_cnt_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        exec_cnt_d  = exec_cnt_q;
        annul_cnt_d = annul_cnt_q;
        if (en) begin
            if (CondEx) begin
                if (exec_cnt_q != {CNT_W{1'b1}}) begin
                    exec_cnt_d = exec_cnt_q + CNT_W'(1);
                end
            end else begin
                if (annul_cnt_q != {CNT_W{1'b1}}) begin
                    annul_cnt_d = annul_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_cnt_q  <= '0;
            annul_cnt_q <= '0;
        end else begin
            exec_cnt_q  <= exec_cnt_d;
            annul_cnt_q <= annul_cnt_d;
        end
    end

    assign exec_cnt  = exec_cnt_q;
    assign annul_cnt = annul_cnt_q;
`else
    assign exec_cnt  = '0;
    assign annul_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_logic.sv
// ============================================================================
// Module : tb_cond_logic
// Brief  : Self-checking bench for cond_logic (directed vectors + model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cond_logic;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] exec_cnt, annul_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    cond_logic #(.CNT_W(CNT_W), .FLAGS_RST(4'b0000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .CondEx    (CondEx),
        .Flags     (Flags),
        .exec_cnt  (exec_cnt),
        .annul_cnt (annul_cnt)
    );

    always #5 clk = ~clk;

    // Reference: conditions come in complementary pairs; odd codes invert
    // the even partner, except NV which never executes.
    function automatic logic pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cf;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cf && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !b : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [3:0] m_flags;
    int         m_exec, m_annul;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_flags <= 4'b0000;
            m_exec  <= 0;
            m_annul <= 0;
        end else if (en) begin
            if (pass(Cond, m_flags)) begin
                m_flags <= { FlagW[1] ? ALUFlags[3:2] : m_flags[3:2],
                             FlagW[0] ? ALUFlags[1:0] : m_flags[1:0] };
                if (m_exec < (1 << CNT_W) - 1) m_exec <= m_exec + 1;
            end else begin
                if (m_annul < (1 << CNT_W) - 1) m_annul <= m_annul + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic ex;
            ex = en && pass(Cond, m_flags);
            chk("CondEx",   {31'd0, CondEx},   {31'd0, ex});
            chk("PCSrc",    {31'd0, PCSrc},    {31'd0, PCS && ex});
            chk("RegWrite", {31'd0, RegWrite}, {31'd0, RegW && ex && !NoWrite});
            chk("MemWrite", {31'd0, MemWrite}, {31'd0, MemW && ex});
            chk("Flags",    {28'd0, Flags},    {28'd0, m_flags});
`ifdef COND_PERF_EN
            chk("exec_cnt",  32'(exec_cnt),  32'(m_exec));
            chk("annul_cnt", 32'(annul_cnt), 32'(m_annul));
`else
            chk("exec_cnt",  32'(exec_cnt),  32'd0);
            chk("annul_cnt", 32'(annul_cnt), 32'd0);
`endif
        end
    end

    // Drive one instruction just after a rising edge; returns at the
    // following falling edge, once the model compare has sampled it.
    task automatic instr(input logic e, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input logic pcs, input logic rw,
                         input logic mw, input logic nw);
        @(posedge clk);
        #1;
        en = e; Cond = c; FlagW = fw; ALUFlags = af;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        @(negedge clk);
    endtask

    task automatic idle();
        instr(1'b0, 4'hE, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic set_flags(input logic [3:0] f);
        instr(1'b1, 4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; Cond = 4'h0; FlagW = 2'b00; ALUFlags = 4'h0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;

        // Reset held for two cycles, even with an executing write pending
        @(posedge clk);
        #1;
        en = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF;
        @(posedge clk);
        #1;
        en = 1'b0; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_Flags",    {28'd0, Flags}, 32'h0);
        chk("rst_strobes",  {29'd0, PCSrc, RegWrite, MemWrite}, 32'h0);
        chk("rst_counters", 32'(exec_cnt) | 32'(annul_cnt), 32'h0);
        reset_n = 1'b1;

        // ADDS
        instr(1'b1, 4'hE, 2'b11, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("adds_RegWrite", {31'd0, RegWrite}, 32'h1);
        idle();
        chk("adds_Flags", {28'd0, Flags}, 32'hA);

        // BEQ not taken, CMP sets Z, BEQ taken
        instr(1'b1, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_nt_PCSrc", {31'd0, PCSrc}, 32'h0);
        instr(1'b1, 4'hE, 2'b11, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("cmp_RegWrite", {31'd0, RegWrite}, 32'h0);
        instr(1'b1, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_t_PCSrc", {31'd0, PCSrc}, 32'h1);
        chk("beq_t_Flags", {28'd0, Flags}, 32'h4);

        // Failing CMPEQ leaves flags alone
        set_flags(4'h3);
        instr(1'b1, 4'h0, 2'b11, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("cmpeq_RegWrite", {31'd0, RegWrite}, 32'h0);
        idle();
        chk("cmpeq_Flags", {28'd0, Flags}, 32'h3);

        // Partial N,Z write
        instr(1'b1, 4'hE, 2'b10, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("partial_MemWrite", {31'd0, MemWrite}, 32'h1);
        instr(1'b1, 4'hF, 2'b11, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("partial_Flags", {28'd0, Flags}, 32'hF);
        chk("nv_CondEx", {31'd0, CondEx}, 32'h0);

        // Sweep every condition over a set of flag patterns; C,V-only write
        for (int p = 0; p < 6; p++) begin
            logic [3:0] pat [6];
            pat = '{4'h0, 4'h4, 4'h2, 4'h9, 4'h8, 4'h6};
            set_flags(pat[p]);
            for (int c = 0; c < 16; c++) begin
                instr(1'b1, 4'(c), 2'b00, 4'h0, 1'(c & 1), 1'b1, 1'(c >> 1), 1'(c >> 3));
            end
        end
        set_flags(4'h0);
        instr(1'b1, 4'hE, 2'b01, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("cv_only_Flags", {28'd0, Flags}, 32'h3);
        chk("gt_hand", {31'd0, pass(4'hC, 4'h9)}, 32'h1);
        chk("ls_hand", {31'd0, pass(4'h9, 4'h2)}, 32'h0);

        // Counters: 3 executed, 2 annulled, 1 idle
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) instr(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) instr(1'b1, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
`ifdef COND_PERF_EN
        chk("exec_3",  32'(exec_cnt),  32'd3);
        chk("annul_2", 32'(annul_cnt), 32'd2);
`else
        chk("exec_tied",  32'(exec_cnt),  32'd0);
        chk("annul_tied", 32'(annul_cnt), 32'd0);
`endif
        for (int i = 0; i < 20; i++) instr(1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
`ifdef COND_PERF_EN
        chk("exec_sat", 32'(exec_cnt), 32'hF);
`else
        chk("exec_sat_tied", 32'(exec_cnt), 32'd0);
`endif

        // Reset discards a same-cycle flag commit
        @(posedge clk);
        #1;
        reset_n = 1'b0; en = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF;
        @(posedge clk);
        #1;
        reset_n = 1'b1; en = 1'b0;
        @(negedge clk);
        chk("rst_wins_Flags", {28'd0, Flags}, 32'h0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
